// File: rtl/negate_pkg.sv
`default_nettype none
// ============================================================================
// Package     : negate_pkg
// Description : Mode encodings and FSM state type shared by the
//               sequential two's-complement unit and its testbench.
// Revision    : 1.0 - initial release
// ============================================================================
package negate_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_NEG  = 2'b01;
  localparam logic [1:0] MODE_ABS  = 2'b10;
  localparam logic [1:0] MODE_ONES = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : negate_pkg
`default_nettype wire

// File: rtl/negate_seq_neg_digit.sv
`default_nettype none
// ============================================================================
// Module      : neg_digit
// Description : One ripple-carry digit slice: {cout, r} = (d ^ inv) + cin.
//               Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module neg_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] d,
  input  logic             inv,
  input  logic             cin,
  output logic [DIGIT-1:0] r,
  output logic             cout
);

  logic [DIGIT:0] w_sum;

  // Conditionally invert the digit and add the incoming carry.
  always_comb begin
    w_sum = {1'b0, d ^ {DIGIT{inv}}} + {{DIGIT{1'b0}}, cin};
  end

  assign r    = w_sum[DIGIT-1:0];
  assign cout = w_sum[DIGIT];

endmodule : neg_digit
`default_nettype wire

// File: rtl/negate_seq.sv
`default_nettype none
// ============================================================================
// Module      : negate_seq
// Description : Digit-serial pass / negate / abs / ones'-complement unit.
//               A WIDTH-bit signed operand is accepted over valid/ready,
//               processed DIGIT bits per cycle, and returned as a
//               WIDTH+1-bit signed result with an overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module negate_seq
  import negate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_data,
  output logic             out_ovf
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(N + 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_res;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic               r_inv;
  logic               r_sign;

  logic [DIGIT-1:0]   w_r;
  logic               w_cout;
  logic [WIDTH-1:0]   w_opnd_nxt;
  logic [WIDTH-1:0]   w_res_nxt;
  logic [WIDTH:0]     w_data_nxt;

  neg_digit #(.DIGIT(DIGIT)) u_digit (
    .d    (r_opnd[DIGIT-1:0]),
    .inv  (r_inv),
    .cin  (r_carry),
    .r    (w_r),
    .cout (w_cout)
  );

  // With a single digit the whole operand is consumed in one step, so the
  // shift slices would be empty; handle that shape separately.
  if (DIGIT == WIDTH) begin : g_single
    assign w_opnd_nxt = '0;
    assign w_res_nxt  = w_r;
  end else begin : g_multi
    assign w_opnd_nxt = {{DIGIT{1'b0}}, r_opnd[WIDTH-1:DIGIT]};
    assign w_res_nxt  = {w_r, r_res[WIDTH-1:DIGIT]};
  end

  // The extra top bit is the sign extension pushed through the same
  // invert-and-carry as the final digit.
  assign w_data_nxt = {r_sign ^ r_inv ^ w_cout, w_res_nxt};

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);

  // Control FSM and datapath registers; results are captured on RUN exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_opnd   <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_inv    <= 1'b0;
      r_sign   <= 1'b0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_opnd  <= in_data;
            r_cnt   <= CNT_W'(N);
            r_sign  <= in_data[WIDTH-1];
            r_state <= RUN;
            case (in_mode)
              MODE_PASS: begin r_inv <= 1'b0; r_carry <= 1'b0; end
              MODE_NEG:  begin r_inv <= 1'b1; r_carry <= 1'b1; end
              MODE_ABS:  begin
                r_inv   <= in_data[WIDTH-1];
                r_carry <= in_data[WIDTH-1];
              end
              default:   begin r_inv <= 1'b1; r_carry <= 1'b0; end
            endcase
          end
        end
        RUN: begin
          r_opnd  <= w_opnd_nxt;
          r_res   <= w_res_nxt;
          r_carry <= w_cout;
          r_cnt   <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state  <= DONE;
            out_data <= w_data_nxt;
            out_ovf  <= w_data_nxt[WIDTH] ^ w_data_nxt[WIDTH-1];
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule : negate_seq
`default_nettype wire

// File: tb/tb_negate_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_negate_seq
// Description : Scoreboard bench for negate_seq. Unit 0 is WIDTH=8/DIGIT=1
//               (directed cases), unit 1 is WIDTH=8/DIGIT=4 (random cases).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_negate_seq;
  import negate_pkg::*;

  typedef struct {
    int         unit;
    logic [8:0] data;
    logic       ovf;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [7:0] in_data   [2];
  logic [1:0] in_mode   [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [8:0] out_data  [2];
  logic       out_ovf   [2];

  exp_t sb_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   rand_rdy = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    negate_seq #(.WIDTH(8), .DIGIT((g == 0) ? 1 : 4)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .in_mode   (in_mode[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .out_ovf   (out_ovf[g])
    );
  end

  // Reference: sign-extend, apply the operation on integers, wrap to 9 bits.
  function automatic logic [9:0] ref_model(logic [1:0] mode, logic [7:0] d);
    int          v;
    int          r;
    logic [31:0] t;
    v = int'($signed(d));
    case (mode)
      MODE_PASS: r = v;
      MODE_NEG:  r = -v;
      MODE_ABS:  r = (v < 0) ? -v : v;
      default:   r = -v - 1;
    endcase
    t = r;
    return {t[8] ^ t[7], t[8:0]};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int u, logic [1:0] m, logic [7:0] d);
    bit         ok;
    logic [9:0] e;
    exp_t       x;
    ok = 1'b0;
    in_valid[u] = 1'b1;
    in_data[u]  = d;
    in_mode[u]  = m;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready[u]) begin
        ok = 1'b1;
        e = ref_model(m, d);
        x.unit = u; x.data = e[8:0]; x.ovf = e[9]; x.acc = cyc;
        sb_q.push_back(x);
      end
      @(posedge clk);
      #1;
    end
    in_valid[u] = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb_q.size() != 0; i++) tick();
    if (sb_q.size() != 0) chk("drain_timeout", sb_q.size(), 0);
    tick();
  endtask

  // Monitor: record out_valid rise times and score every completed transfer.
  task automatic monitor();
    bit   prev_v [2];
    int   rise   [2];
    exp_t x;
    prev_v[0] = 1'b0; prev_v[1] = 1'b0;
    rise[0] = 0; rise[1] = 0;
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        if (out_valid[u] && !prev_v[u]) rise[u] = cyc;
        prev_v[u] = out_valid[u];
        if (!rst && out_valid[u] && out_ready[u]) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            x = sb_q.pop_front();
            chk("unit", u, x.unit);
            chk("out_data", out_data[u], x.data);
            chk("out_ovf", out_ovf[u], x.ovf);
            chk("latency", rise[u] - x.acc, (u == 0) ? 9 : 3);
          end
        end
      end
    end
  endtask

  logic [1:0] dir_mode [9] = '{MODE_NEG, MODE_NEG, MODE_ABS, MODE_PASS,
                               MODE_ONES, MODE_ABS, MODE_ABS, MODE_NEG,
                               MODE_PASS};
  logic [7:0] dir_data [9] = '{8'h05, 8'h80, 8'h80, 8'h80, 8'h80,
                               8'hFF, 8'h7F, 8'h00, 8'h7F};

  initial begin
    logic [9:0] e;
    bit         seen;
    for (int u = 0; u < 2; u++) begin
      in_valid[u] = 1'b0; in_data[u] = '0; in_mode[u] = '0; out_ready[u] = 1'b1;
    end
    fork
      monitor();
      forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready[1] = 1'($urandom_range(0, 1));
      end
      begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
      end
    join_none

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("rst_in_ready", in_ready[u], 1);
      chk("rst_out_valid", out_valid[u], 0);
      chk("rst_out_data", out_data[u], 0);
      chk("rst_out_ovf", out_ovf[u], 0);
    end
    tick();
    rst = 1'b0;
    tick();

    // Directed operands on the bit-serial unit
    for (int i = 0; i < 9; i++) send(0, dir_mode[i], dir_data[i]);
    drain();

    // Backpressure plus an offered operand while busy
    out_ready[0] = 1'b0;
    send(0, MODE_NEG, 8'h33);
    in_valid[0] = 1'b1;
    in_data[0]  = 8'hAA;
    in_mode[0]  = MODE_PASS;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid[0]) seen = 1'b1;
      else chk("run_in_ready", in_ready[0], 0);
      tick();
    end
    if (!seen) chk("valid_timeout", 0, 1);
    e = ref_model(MODE_NEG, 8'h33);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", out_valid[0], 1);
      chk("hold_in_ready", in_ready[0], 0);
      chk("hold_out_data", out_data[0], e[8:0]);
      tick();
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    drain();

    // Reset in the third RUN cycle
    send(0, MODE_NEG, 8'h55);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready[0], 1);
    chk("midrst_out_valid", out_valid[0], 0);
    chk("midrst_out_data", out_data[0], 0);
    sb_q.delete();
    tick();
    send(0, MODE_NEG, 8'h01);
    drain();

    // Random operands and modes with random consumer stalls on DIGIT=4
    rand_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      send(1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end
    rand_rdy = 1'b0;
    tick();
    out_ready[1] = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_negate_seq
`default_nettype wire
